// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer for the EX stage.
// MUL/MULH/MULHSU/MULHU use 32 shift-add steps; DIV/DIVU/REM/REMU use 32
// restoring-divide steps. Divide-by-zero and signed overflow skip iteration.
// Build option: define MDU_DIV_EN to include the divider. Without it, every
// funct3 1xx op takes the fast path and returns 0.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [5:0]        r_cnt;
  logic [2:0]        r_f3;
  logic              r_sa, r_sb;
  logic [2*XLEN-1:0] r_acc;   // mul: {hi acc, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   r_opb;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]   r_result;

  logic              w_sgn_a, w_sgn_b, w_sa, w_sb;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

  // Operand signedness: rs1 signed for MULH/MULHSU/DIV/REM, rs2 for MULH/DIV/REM
  assign w_sgn_a = (funct3_i == 3'b001) | (funct3_i == 3'b010) | (funct3_i[2] & ~funct3_i[0]);
  assign w_sgn_b = (funct3_i == 3'b001) | (funct3_i[2] & ~funct3_i[0]);
  assign w_sa    = w_sgn_a & a_i[XLEN-1];
  assign w_sb    = w_sgn_b & b_i[XLEN-1];
  assign w_mag_a = w_sa ? (~a_i + 1'b1) : a_i;
  assign w_mag_b = w_sb ? (~b_i + 1'b1) : b_i;

  // Shift-add step: add multiplicand on multiplier LSB, then shift right with carry
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);

`ifdef MDU_DIV_EN
  logic          w_dz, w_ovf;
  logic [XLEN:0] w_rem_sh;
  logic [XLEN+1:0] w_diff;

  assign w_dz   = (b_i == '0);
  assign w_ovf  = ~funct3_i[0] & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);
  assign w_fast = funct3_i[2] & (w_dz | w_ovf);
  // Divide by zero wins over overflow (b=0 cannot be -1 anyway)
  assign w_fast_res = w_dz  ? (funct3_i[1] ? a_i : '1)
                            : (funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  // Restoring step: shifted remainder can reach XLEN+1 bits, so compare one bit wider
  assign w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_opb};

  // Per-iteration update of the working register
  always_comb begin
    w_acc_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
    if (r_f3[2]) begin
      if (!w_diff[XLEN+1]) w_acc_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      else                 w_acc_nxt = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end
  end
`else
  assign w_fast     = funct3_i[2];
  assign w_fast_res = '0;
  assign w_acc_nxt  = {w_mul_sum, r_acc[XLEN-1:1]};
`endif

  // Sign fix-up: product/quotient take sa^sb, remainder takes the dividend sign
  assign w_prod = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = r_sa ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  // Result select by op
  always_comb begin
    w_fix_res = w_prod[2*XLEN-1:XLEN];
    case (r_f3)
      3'b000:         w_fix_res = w_prod[XLEN-1:0];
      3'b100, 3'b101: w_fix_res = w_quo;
      3'b110, 3'b111: w_fix_res = w_rem;
      default:        w_fix_res = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  // Sequencer: issue, iterate, fix up, present result; flush always wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
        end
        default: begin  // IDLE and DONE both accept a new op
          if (start_i) begin
            r_f3 <= funct3_i;
            r_sa <= w_sa;
            r_sb <= w_sb;
            if (w_fast) begin
              r_result <= w_fast_res;
              r_state  <= S_DONE;
            end else begin
              r_acc   <= {{XLEN{1'b0}}, w_mag_a};
              r_opb   <= w_mag_b;
              r_cnt   <= '0;
              r_state <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign stall_o  = rst_n & ((start_i & ~flush_i) | (r_state == S_CALC) | (r_state == S_FIX));
  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = (r_state == S_DONE);
  assign result_o = r_result;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed-vector bench for mdu_seq (follows MDU_DIV_EN if defined).
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .stall_o(stall_o),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  // Issue one op in the current cycle (now=1) or the next one, run until done.
  // Leaves the bench in the done cycle, #1 after the negedge. lat=0 on timeout.
  task automatic do_op(input bit now, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output int lat, output logic [31:0] res,
                       output bit st0, output bit st_ok, output bit st_done);
    lat = 0; res = 'x; st_ok = 1'b1; st_done = 1'b1;
    if (!now) @(negedge clk);
    start_i = 1'b1; funct3_i = f3; a_i = a; b_i = b;
    #1 st0 = stall_o;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      #1;
      if (done_o) begin
        lat = c; res = result_o; st_done = stall_o;
        break;
      end
      if (!stall_o) st_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_i = 0; flush_i = 0; funct3_i = 0; a_i = 0; b_i = 0;
    #12;
    n_cmp++;
    if ({stall_o, busy_o, done_o, result_o} !== 35'd0) begin
      n_bad++; $display("FAIL reset_outputs: got s%b b%b d%b r%h, want all 0",
                        stall_o, busy_o, done_o, result_o);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mul;
    int lat; logic [31:0] r; bit s0, sok, sd;
    do_op(0, 3'b000, 32'd7, 32'd6, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== 34 || r !== 32'h2A) begin
      n_bad++; $display("FAIL mul_7x6: got lat %0d res %h, want 34 0000002a", lat, r);
    end
    n_cmp++;
    if (!(s0 && sok && !sd)) begin
      n_bad++; $display("FAIL mul_stall: got c0=%b mid=%b done=%b, want 1 1 0", s0, sok, sd);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_bad++; $display("FAIL mul_busy_after: got busy %b done %b, want 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_mulh;
    int lat; logic [31:0] r; bit s0, sok, sd;
    do_op(0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== 34 || r !== 32'h0) begin
      n_bad++; $display("FAIL mulh: got lat %0d res %h, want 34 00000000", lat, r);
    end
    do_op(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== 34 || r !== 32'hFFFFFFFE) begin
      n_bad++; $display("FAIL mulhu: got lat %0d res %h, want 34 fffffffe", lat, r);
    end
    do_op(0, 3'b010, 32'hFFFFFFFF, 32'd2, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== 34 || r !== 32'hFFFFFFFF) begin
      n_bad++; $display("FAIL mulhsu: got lat %0d res %h, want 34 ffffffff", lat, r);
    end
    do_op(0, 3'b000, 32'hFFFFFFFD, 32'd5, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== 34 || r !== 32'hFFFFFFF1) begin
      n_bad++; $display("FAIL mul_neg: got lat %0d res %h, want 34 fffffff1", lat, r);
    end
  endtask

  task automatic test_div;
    int lat; logic [31:0] r; bit s0, sok, sd;
    int el = DIV_EN ? 34 : 1;
    do_op(0, 3'b100, 32'hFFFFFFF9, 32'd2, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== el || r !== (DIV_EN ? 32'hFFFFFFFD : 32'h0)) begin
      n_bad++; $display("FAIL div_m7_2: got lat %0d res %h, want %0d %h", lat, r, el,
                        DIV_EN ? 32'hFFFFFFFD : 32'h0);
    end
    do_op(0, 3'b110, 32'hFFFFFFF9, 32'd2, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== el || r !== (DIV_EN ? 32'hFFFFFFFF : 32'h0)) begin
      n_bad++; $display("FAIL rem_m7_2: got lat %0d res %h, want %0d %h", lat, r, el,
                        DIV_EN ? 32'hFFFFFFFF : 32'h0);
    end
    do_op(0, 3'b111, 32'd7, 32'd2, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== el || r !== (DIV_EN ? 32'd1 : 32'h0)) begin
      n_bad++; $display("FAIL remu_7_2: got lat %0d res %h, want %0d %h", lat, r, el,
                        DIV_EN ? 32'd1 : 32'h0);
    end
    do_op(0, 3'b101, 32'hFFFFFFF0, 32'd3, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== el || r !== (DIV_EN ? 32'h55555550 : 32'h0)) begin
      n_bad++; $display("FAIL divu_big: got lat %0d res %h, want %0d %h", lat, r, el,
                        DIV_EN ? 32'h55555550 : 32'h0);
    end
  endtask

  task automatic test_fast_path;
    int lat; logic [31:0] r; bit s0, sok, sd;
    do_op(0, 3'b101, 32'd5, 32'd0, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== 1 || r !== (DIV_EN ? 32'hFFFFFFFF : 32'h0) || !s0 || sd) begin
      n_bad++; $display("FAIL divu_by0: got lat %0d res %h st %b/%b, want 1 %h 1/0", lat, r,
                        s0, sd, DIV_EN ? 32'hFFFFFFFF : 32'h0);
    end
    do_op(0, 3'b110, 32'd9, 32'd0, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== 1 || r !== (DIV_EN ? 32'd9 : 32'h0)) begin
      n_bad++; $display("FAIL rem_by0: got lat %0d res %h, want 1 %h", lat, r,
                        DIV_EN ? 32'd9 : 32'h0);
    end
    do_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== 1 || r !== (DIV_EN ? 32'h80000000 : 32'h0)) begin
      n_bad++; $display("FAIL div_ovf: got lat %0d res %h, want 1 %h", lat, r,
                        DIV_EN ? 32'h80000000 : 32'h0);
    end
    do_op(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== 1 || r !== 32'h0) begin
      n_bad++; $display("FAIL rem_ovf: got lat %0d res %h, want 1 00000000", lat, r);
    end
  endtask

  task automatic test_flush;
    int lat; logic [31:0] r; bit s0, sok, sd; bit seen_done = 0;
    do_op(0, 3'b000, 32'd7, 32'd6, lat, r, s0, sok, sd);  // result 0x2a
    @(negedge clk); #1;
    @(negedge clk);                                     // cycle 0
    start_i = 1'b1; funct3_i = 3'b000; a_i = 32'h1234; b_i = 32'd5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); start_i = 1'b0;
      if (c == 10) flush_i = 1'b1;
      #1 if (done_o) seen_done = 1;
    end
    @(negedge clk); flush_i = 1'b0; #1;                 // cycle 11
    n_cmp++;
    if (seen_done || done_o || stall_o || busy_o || result_o !== 32'h2A) begin
      n_bad++; $display("FAIL flush: got done %b/%b stall %b busy %b res %h, want 0/0 0 0 0000002a",
                        seen_done, done_o, stall_o, busy_o, result_o);
    end
    do_op(0, 3'b000, 32'd3, 32'd3, lat, r, s0, sok, sd);  // start cycle 12
    n_cmp++;
    if (lat !== 34 || r !== 32'd9) begin
      n_bad++; $display("FAIL flush_restart: got lat %0d res %h, want 34 00000009", lat, r);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] r; bit s0, sok, sd;
    do_op(0, 3'b000, 32'd11, 32'd12, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== 34 || r !== 32'd132) begin
      n_bad++; $display("FAIL b2b_first: got lat %0d res %h, want 34 00000084", lat, r);
    end
    do_op(1, 3'b011, 32'h00010000, 32'h00030000, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== 34 || r !== 32'd3 || !s0 || !sok) begin
      n_bad++; $display("FAIL b2b_second: got lat %0d res %h st %b%b, want 34 00000003 11",
                        lat, r, s0, sok);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] r; bit s0, sok, sd;
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b000; a_i = 32'd100; b_i = 32'd7;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); start_i = 1'b0;
    end
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({stall_o, busy_o, done_o, result_o} !== 35'd0) begin
      n_bad++; $display("FAIL reset_mid: got s%b b%b d%b r%h, want all 0",
                        stall_o, busy_o, done_o, result_o);
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(0, 3'b100, 32'd100, 32'd7, lat, r, s0, sok, sd);
    n_cmp++;
    if (lat !== (DIV_EN ? 34 : 1) || r !== (DIV_EN ? 32'd14 : 32'd0)) begin
      n_bad++; $display("FAIL div_100_7: got lat %0d res %h, want %0d %h", lat, r,
                        DIV_EN ? 34 : 1, DIV_EN ? 32'd14 : 32'd0);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast_path();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
